// File: rtl/uart_cmd_host.sv
// UART command initiator: sends a 6-byte command frame, collects a 5-byte reply.
// Optional macro UART_CMD_HOST_TRAILER_CHECK_EN flags a non-zero reply trailer.
module uart_cmd_host #(
    parameter logic [7:0] END_BYTE       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 240000,
    parameter int         TO_W           = 18
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_rcv,
    input  logic [7:0]  rx_data
);

    typedef enum logic [2:0] {
        IDLE, TX_LOAD, TX_WAIT_LO, TX_WAIT_HI, RX, DONE
    } state_t;

    state_t          state, state_nx;
    logic [47:0]     frame;
    logic [2:0]      idx;
    logic [2:0]      rx_cnt;
    logic [31:0]     rx_sh;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      cur_byte;
    logic            to_hit;
    logic            rx_last;
    logic            trl_err;

    assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign rx_last = rx_rcv && (rx_cnt == 3'd4);

`ifdef UART_CMD_HOST_TRAILER_CHECK_EN
    assign trl_err = (rx_data != 8'h00);
`else
    assign trl_err = 1'b0;
`endif

    always_comb begin
        cur_byte = 8'h00;
        unique case (idx)
            3'd0:    cur_byte = frame[47:40];
            3'd1:    cur_byte = frame[39:32];
            3'd2:    cur_byte = frame[31:24];
            3'd3:    cur_byte = frame[23:16];
            3'd4:    cur_byte = frame[15:8];
            3'd5:    cur_byte = frame[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:       if (cmd_valid) state_nx = TX_LOAD;
            TX_LOAD:    if (tx_ready) state_nx = TX_WAIT_LO;
            TX_WAIT_LO: if (!tx_ready) state_nx = TX_WAIT_HI;
            TX_WAIT_HI: if (tx_ready) state_nx = (idx == 3'd5) ? RX : TX_LOAD;
            RX:         if (rx_last || (!rx_rcv && to_hit)) state_nx = DONE;
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // Start is held through the UART's delayed ready fall.
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign tx_start  = ((state == TX_LOAD) && tx_ready) || (state == TX_WAIT_LO);
    assign tx_data   = cur_byte;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            frame    <= '0;
            idx      <= '0;
            rx_cnt   <= '0;
            rx_sh    <= '0;
            to_cnt   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        frame <= {cmd_op, cmd_arg, END_BYTE};
                        idx   <= '0;
                    end
                end
                TX_WAIT_HI: begin
                    if (tx_ready) begin
                        if (idx == 3'd5) begin
                            rx_cnt <= '0;
                            to_cnt <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                RX: begin
                    // A byte landing on the expiry cycle wins over the timeout.
                    if (rx_rcv) begin
                        rx_sh  <= {rx_sh[23:0], rx_data};
                        rx_cnt <= rx_cnt + 3'd1;
                        to_cnt <= '0;
                        if (rx_last) begin
                            rsp_data <= rx_sh;
                            rsp_err  <= trl_err;
                        end
                    end else if (to_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host with a negedge-driven uart_tx model.
module tb_uart_cmd_host;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_op = 8'h00;
    logic [31:0] cmd_arg = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        rx_rcv = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tx_n = 0;
    int tx_cnt = 0;
    int hold_err = 0;
    int rise_cyc = 0;
    int last_rcv_cyc = 0;
    logic [7:0] tx_bytes [0:15];

`ifdef UART_CMD_HOST_TRAILER_CHECK_EN
    localparam logic TRL_ERR = 1'b1;
`else
    localparam logic TRL_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_cmd_host #(
        .END_BYTE(8'h00),
        .TIMEOUT_CYCLES(50),
        .TO_W(18)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .rx_rcv(rx_rcv),
        .rx_data(rx_data)
    );

    // uart_tx model: ready falls 2 cycles after start, rises 4 later.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_cnt == 0) begin
            if (tx_start) begin
                if (tx_n < 16) tx_bytes[tx_n] = tx_data;
                tx_n = tx_n + 1;
                tx_cnt = 1;
            end
        end else begin
            if (tx_cnt <= 2 && tx_start !== 1'b1) hold_err = hold_err + 1;
            if (tx_cnt >= 3 && tx_start !== 1'b0) hold_err = hold_err + 1;
            tx_cnt = tx_cnt + 1;
            if (tx_cnt == 3) tx_ready = 1'b0;
            if (tx_cnt == 7) begin
                tx_ready = 1'b1;
                tx_cnt = 0;
                rise_cyc = cyc;
            end
        end
    end

    function automatic logic [47:0] frame_at(input int b);
        return {tx_bytes[b], tx_bytes[b+1], tx_bytes[b+2],
                tx_bytes[b+3], tx_bytes[b+4], tx_bytes[b+5]};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] arg);
        int k;
        k = 0;
        while (!cmd_ready && k < 200) begin
            step();
            k++;
        end
        if (k == 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_ready_wait: got 0 want 1");
        end
        tx_n = 0;
        cmd_op = op;
        cmd_arg = arg;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (tx_n == target && tx_cnt == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic send_reply(input logic [39:0] r);
        for (int i = 0; i < 5; i++) begin
            step();
            step();
            rx_data = r[39-8*i -: 8];
            rx_rcv = 1'b1;
            last_rcv_cyc = cyc;
            step();
            rx_rcv = 1'b0;
        end
    endtask

    task automatic wait_rsp(output bit got, output int at);
        got = 1'b0;
        at = 0;
        for (int k = 0; k < 200; k++) begin
            if (rsp_valid) begin
                got = 1'b1;
                at = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid);
        end
        n_cmp++;
        if (rsp_data !== 32'h0) begin
            n_bad++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data);
        end
        n_cmp++;
        if (rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err);
        end
        n_cmp++;
        if (tx_start !== 1'b0) begin
            n_bad++; $display("FAIL rst_tx_start: got %b want 0", tx_start);
        end
        n_cmp++;
        if (tx_data !== 8'h00) begin
            n_bad++; $display("FAIL rst_tx_data: got %h want 0", tx_data);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_const();
        bit ok, got;
        int at;
        send_cmd(8'h07, 32'h0);
        wait_tx_done(6, ok);
        n_cmp++;
        if (!ok || frame_at(0) !== 48'h07_00_00_00_00_00) begin
            n_bad++; $display("FAIL const_frame: got %h want 070000000000", frame_at(0));
        end
        send_reply(40'h00_00_01_03_00);
        wait_rsp(got, at);
        n_cmp++;
        if (!got || rsp_data !== 32'h0000_0103) begin
            n_bad++; $display("FAIL const_data: got %h want 00000103", rsp_data);
        end
        n_cmp++;
        if (rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL const_err: got %b want 0", rsp_err);
        end
        n_cmp++;
        if (at - last_rcv_cyc !== 1) begin
            n_bad++; $display("FAIL const_latency: got %0d want 1", at - last_rcv_cyc);
        end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL const_ready_done: got %b want 0", cmd_ready);
        end
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL const_after: got %b%b want 10", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_addr();
        bit ok, got;
        int at;
        send_cmd(8'h01, 32'h0000_1234);
        wait_tx_done(6, ok);
        n_cmp++;
        if (!ok || frame_at(0) !== 48'h01_00_00_12_34_00) begin
            n_bad++; $display("FAIL addr_frame: got %h want 010000123400", frame_at(0));
        end
        send_reply(40'h00_00_12_34_00);
        wait_rsp(got, at);
        n_cmp++;
        if (!got || rsp_data !== 32'h0000_1234) begin
            n_bad++; $display("FAIL addr_data: got %h want 00001234", rsp_data);
        end
        n_cmp++;
        if (hold_err !== 0) begin
            n_bad++; $display("FAIL tx_start_hold: got %0d errors want 0", hold_err);
        end
        step();
    endtask

    task automatic test_timeout();
        bit ok, got;
        int at;
        send_cmd(8'h04, 32'h0000_0010);
        wait_tx_done(6, ok);
        wait_rsp(got, at);
        n_cmp++;
        if (!ok || !got || at - rise_cyc !== 51) begin
            n_bad++; $display("FAIL timeout_latency: got %0d want 51", at - rise_cyc);
        end
        n_cmp++;
        if (rsp_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_err: got %b want 1", rsp_err);
        end
        n_cmp++;
        if (rsp_data !== 32'h0) begin
            n_bad++; $display("FAIL timeout_data: got %h want 0", rsp_data);
        end
        step();
    endtask

    task automatic test_trailer();
        bit ok, got;
        int at;
        send_cmd(8'h04, 32'h0000_0020);
        wait_tx_done(6, ok);
        send_reply(40'h11_22_33_44_AA);
        wait_rsp(got, at);
        n_cmp++;
        if (!ok || !got || rsp_data !== 32'h1122_3344) begin
            n_bad++; $display("FAIL trailer_data: got %h want 11223344", rsp_data);
        end
        n_cmp++;
        if (rsp_err !== TRL_ERR) begin
            n_bad++; $display("FAIL trailer_err: got %b want %b", rsp_err, TRL_ERR);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit ok, got;
        int at, k, seen;
        send_cmd(8'h03, 32'hCAFE_0001);
        k = 0;
        while (!(tx_n == 3 && tx_cnt == 4) && k < 200) begin
            step();
            k++;
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (k == 200 || {cmd_ready, rsp_valid, rsp_err, tx_start} !== 4'b1000) begin
            n_bad++; $display("FAIL midrst_flags: got %b want 1000",
                              {cmd_ready, rsp_valid, rsp_err, tx_start});
        end
        n_cmp++;
        if (rsp_data !== 32'h0 || tx_data !== 8'h00) begin
            n_bad++; $display("FAIL midrst_data: got %h/%h want 0/0", rsp_data, tx_data);
        end
        step();
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL midrst_no_rsp: got %0d want 0", seen);
        end
        send_cmd(8'h06, 32'h0);
        wait_tx_done(6, ok);
        n_cmp++;
        if (!ok || frame_at(0) !== 48'h06_00_00_00_00_00) begin
            n_bad++; $display("FAIL count_frame: got %h want 060000000000", frame_at(0));
        end
        send_reply(40'h00_00_00_2A_00);
        wait_rsp(got, at);
        n_cmp++;
        if (!got || rsp_data !== 32'h0000_002A || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL count_rsp: got %h/%b want 0000002a/0", rsp_data, rsp_err);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit ok, got;
        int at, k;
        tx_n = 0;
        cmd_op = 8'h01;
        cmd_arg = 32'h0000_00A5;
        cmd_valid = 1'b1;
        step();
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept1: got %b want 0", cmd_ready);
        end
        cmd_op = 8'h02;
        cmd_arg = 32'h5A5A_0F0F;
        k = 0;
        while (tx_n < 2 && k < 200) begin
            step();
            k++;
        end
        rx_data = 8'hEE;
        rx_rcv = 1'b1;
        step();
        rx_rcv = 1'b0;
        wait_tx_done(6, ok);
        n_cmp++;
        if (!ok || frame_at(0) !== 48'h01_00_00_00_A5_00) begin
            n_bad++; $display("FAIL b2b_frame1: got %h want 01000000a500", frame_at(0));
        end
        send_reply(40'h00_00_00_A5_00);
        wait_rsp(got, at);
        n_cmp++;
        if (!got || rsp_data !== 32'h0000_00A5 || tx_n !== 6) begin
            n_bad++; $display("FAIL b2b_rsp1: got %h tx %0d want 000000a5 tx 6", rsp_data, tx_n);
        end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_ready_done: got %b want 0", cmd_ready);
        end
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready_idle: got %b want 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept2: got %b want 0", cmd_ready);
        end
        wait_tx_done(12, ok);
        n_cmp++;
        if (!ok || frame_at(6) !== 48'h02_5A_5A_0F_0F_00) begin
            n_bad++; $display("FAIL b2b_frame2: got %h want 025a5a0f0f00", frame_at(6));
        end
        send_reply(40'h12_34_56_78_00);
        wait_rsp(got, at);
        n_cmp++;
        if (!got || rsp_data !== 32'h1234_5678 || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL b2b_rsp2: got %h/%b want 12345678/0", rsp_data, rsp_err);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_const();
        test_addr();
        test_timeout();
        test_trailer();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_host.md
# uart_cmd_host

- Hardware initiator for the 6-byte UART command protocol served by the HyperRAM test top.
- Takes one command (opcode plus 32-bit argument) from local logic, serialises it as a frame through a `uart_tx`, and collects the 5-byte reply through a `uart_rx`.
- Returns the reply as a 32-bit word.
- Used for board-to-board loopback and for self-test of the HyperRAM command path without a PC.

## Interface
Parameters:
- `END_BYTE`, 8'h00: value sent as frame byte 5 (trailer). The far end ignores it.
- `TIMEOUT_CYCLES`, 240000: reply-silence limit in `clk` cycles (10 ms at 24 MHz). Must be ≥ 2.
- `TO_W`, 18: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- `clk` in 1: single clock. Same domain as the attached UART.
- `rstn` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block idle; command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 8: opcode (1 ADDR, 2 LOAD, 3 WRITE, 4 READ, 5 READ_REQ, 6 COUNT, 7 CONST).
- `cmd_arg` in 32: argument, sent MSB byte first.
- `rsp_valid` out 1: one-cycle pulse, reply complete or failed.
- `rsp_data` out 32: reply word, big-endian from reply bytes 0..3. Holds its value until the next `rsp_valid`.
- `rsp_err` out 1: qualified by `rsp_valid`. Set on timeout, or on trailer mismatch when the macro is enabled.
- `tx_start` out 1: to `uart_tx.start`.
- `tx_data` out 8: to `uart_tx.data`.
- `tx_ready` in 1: from `uart_tx.ready`.
- `rx_rcv` in 1: from `uart_rx.rcv`, one-cycle byte strobe.
- `rx_data` in 8: from `uart_rx.data`.

## Operation
- States: IDLE, TX_LOAD, TX_WAIT_LO, TX_WAIT_HI, RX, DONE.
- IDLE
  - `cmd_ready`=1.
  - On accept, latch frame {op, arg[31:24], arg[23:16], arg[15:8], arg[7:0], END_BYTE} and set byte index 0.
  - Go to TX_LOAD.
- TX_LOAD
  - Wait for `tx_ready`=1.
  - Drive `tx_data` = frame[index] and `tx_start`=1, then go to TX_WAIT_LO.
- TX_WAIT_LO
  - Hold `tx_start`=1 and `tx_data` stable until `tx_ready` is sampled 0.
  - Then drop `tx_start` and go to TX_WAIT_HI. This covers the UART's 2-cycle ready-fall delay.
- TX_WAIT_HI
  - Wait for `tx_ready`=1.
  - If index=5: clear the reply byte counter and the timeout counter, then go to RX.
  - Otherwise increment index and go to TX_LOAD.
- RX
  - Each `rx_rcv` shifts `rx_data` into a 40-bit register (left shift, new byte at LSB), increments the byte count, and clears the timeout counter.
  - On the 5th byte go to DONE.
  - If the timeout counter reaches TIMEOUT_CYCLES with no byte, go to DONE with err=1.
- DONE
  - One cycle: `rsp_valid`=1.
  - `rsp_data` = reg[39:8] on success, 0 on timeout.
  - Return to IDLE.
- `rx_rcv` outside RX is discarded; the counters are unaffected.
- A new command cannot be accepted in the DONE cycle.
- An `rx_rcv` coinciding with the timeout expiry cycle counts as a byte; the timeout is not taken.

## Timing
- Reset values (asynchronous assertion, synchronous release):
  - `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `tx_start`=0, `tx_data`=0.
  - State IDLE; all counters 0.
- Reset asserted mid-frame or mid-reply aborts the transaction. No `rsp_valid` is produced. Bytes in flight on the UART are not recalled.
- The accept edge is registered: `tx_start` rises no earlier than 1 cycle after accept.
- `cmd_ready` falls the cycle after accept and rises the cycle after `rsp_valid`.
- Exactly 6 `tx_start` assertions per command, in frame order. None after index 5.
- `rsp_valid` follows the 5th `rx_rcv` by exactly 1 cycle.
- `rsp_valid` follows timeout expiry by exactly 1 cycle.

## Configuration
- `UART_CMD_HOST_TRAILER_CHECK_EN`
  - Defined: reply byte 4 (the 5th byte) must equal 8'h00. A mismatch sets `rsp_err`=1; `rsp_data` still carries bytes 0..3.
  - Undefined: byte 4 is received and ignored, and `rsp_err` reflects timeout only.

## Test plan
- CONST command (op 7, arg 0) against a UART model replying 00 00 01 03 00 -> TX bytes 07 00 00 00 00 00; `rsp_data`=0x00000103, `rsp_err`=0, `rsp_valid` 1 cycle after the 5th `rx_rcv`.
- ADDR with arg 0x00001234 -> TX 01 00 00 12 34 00; echo reply gives `rsp_data`=0x00001234. Check `tx_start` is held until `tx_ready` falls 2 cycles late.
- No reply after frame, TIMEOUT_CYCLES=50 -> `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 exactly 51 cycles after the final `tx_ready` rise.
- Reply 11 22 33 44 AA -> `rsp_data`=0x11223344. `rsp_err`=1 with `UART_CMD_HOST_TRAILER_CHECK_EN` defined, 0 without.
- `rstn` pulsed low after the 3rd TX byte -> all outputs at reset values within the same cycle, no `rsp_valid`. A following COUNT command completes normally.
- Two back-to-back commands with `cmd_valid` held high, plus stray `rx_rcv` during TX -> second accept occurs only after the first `rsp_valid`, and stray bytes do not appear in `rsp_data`.
